lab7_sos_pio_in_edge: RTL and testbench

- Parametrised Avalon-MM slave input PIO for board switches and keys. Successor to the fixed 2-bit read-only input port.
- Adds a configurable width, a per-bit synchroniser, an optional debounce filter, per-bit edge capture, an interrupt mask and a level interrupt output.
- Sits on the Nios II data master bus. The irq output goes to the processor interrupt controller.

---
 rtl/lab7_sos_pio_pkg.sv | 12 +
 rtl/lab7_sos_pio_debounce.sv | 54 +++++
 rtl/lab7_sos_pio_in_edge.sv | 102 ++++++++++
 tb/tb_lab7_sos_pio_in_edge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab7_sos_pio_pkg.sv
// Shared constants for the switch/key input PIO: register addresses and edge-type codes.
package lab7_sos_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lab7_sos_pio_debounce.sv
// One input bit: multi-flop synchroniser followed by an optional stable-count debounce filter.
module lab7_sos_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic out_bit
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign out_bit = w_sync;
        end else begin : g_filter
            localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

            logic [15:0] r_cnt;
            logic        r_filt;

            // Any cycle where the synced bit agrees with the filtered value restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (w_sync == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_filt <= w_sync;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign out_bit = r_filt;
        end
    endgenerate

endmodule

// File: rtl/lab7_sos_pio_in_edge.sv
// Avalon-MM input PIO: filtered inputs, per-bit edge capture with W1C, irq mask, registered level irq.
module lab7_sos_pio_in_edge
    import lab7_sos_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_data_f;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_wr;

    logic [WIDTH-1:0] r_data_d;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [31:0]      r_readdata;
    logic             r_irq;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            lab7_sos_pio_debounce #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .in_bit (in_port[i]),
                .out_bit(w_data_f[i])
            );
        end

        if (WIDTH < 32) begin : g_unused
            logic w_unused_wdata;
            assign w_unused_wdata = |writedata[31:WIDTH];
        end
    endgenerate

    assign w_wr   = chipselect & ~write_n;
    assign w_rise = w_data_f & ~r_data_d;
    assign w_fall = ~w_data_f & r_data_d;
    assign w_clr  = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_edge = w_rise | w_fall;
        case (EDGE_TYPE)
            EDGE_RISE: w_edge = w_rise;
            EDGE_FALL: w_edge = w_fall;
            EDGE_ANY:  w_edge = w_rise | w_fall;
            default:   w_edge = w_rise;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_data_f;
            ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
            default:      w_rd_mux = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear, so set wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_d   <= '0;
            r_edgecap  <= '0;
            r_irqmask  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_data_d   <= w_data_f;
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr && address == ADDR_IRQMASK) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_readdata <= w_rd_mux;
            r_irq      <= |(r_edgecap & r_irqmask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_lab7_sos_pio_in_edge.sv
// Self-checking bench: three PIO configurations against a history-based behavioural model.
`timescale 1ns/1ps
module tb_lab7_sos_pio_in_edge;

    localparam int ND = 3;
    localparam int HN = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  adr [ND];
    logic        cs  [ND];
    logic        wn  [ND];
    logic [31:0] wd  [ND];
    logic [31:0] pin [ND];
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int n_err = 0;
    int n_checks = 0;

    // Model state
    logic [31:0] hist [ND][HN];
    logic [31:0] m_f [ND];
    logic [31:0] m_d [ND];
    logic [31:0] m_ec [ND];
    logic [31:0] m_mask [ND];
    logic [31:0] m_rd [ND];
    logic        m_irq [ND];
    int          cyc = 0;

    always #5 clk = ~clk;

    // A: 8 bits, 2-stage sync, no debounce, rising. B: debounce 4, falling. C: 32 bits, 3-stage, any edge.
    lab7_sos_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(adr[0]), .chipselect(cs[0]), .write_n(wn[0]),
        .writedata(wd[0]), .in_port(pin[0][7:0]), .readdata(rd_a), .irq(irq_a));
    lab7_sos_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(adr[1]), .chipselect(cs[1]), .write_n(wn[1]),
        .writedata(wd[1]), .in_port(pin[1][7:0]), .readdata(rd_b), .irq(irq_b));
    lab7_sos_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .address(adr[2]), .chipselect(cs[2]), .write_n(wn[2]),
        .writedata(wd[2]), .in_port(pin[2]), .readdata(rd_c), .irq(irq_c));

    function automatic int s_of(input int n);
        return (n == 2) ? 3 : 2;
    endfunction
    function automatic int d_of(input int n);
        return (n == 1) ? 4 : 0;
    endfunction
    function automatic int e_of(input int n);
        return n;
    endfunction
    function automatic logic [31:0] wmask(input int n);
        return (n == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction
    function automatic logic [31:0] dut_rd(input int n);
        return (n == 0) ? rd_a : (n == 1) ? rd_b : rd_c;
    endfunction
    function automatic logic dut_irq(input int n);
        return (n == 0) ? irq_a : (n == 1) ? irq_b : irq_c;
    endfunction
    function automatic logic [31:0] h(input int n, input int k);
        return (k < 0) ? 32'h0 : hist[n][k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: filtered value derived from the input history; registers from the bus rules.
    always @(posedge clk) begin
        logic [31:0] f_new, ed, clr, mk, sv;
        logic        wr, flip;
        for (int n = 0; n < ND; n++) begin
            if (!reset_n) begin
                hist[n][cyc] = '0;
                m_f[n] = '0; m_d[n] = '0; m_ec[n] = '0; m_mask[n] = '0; m_rd[n] = '0; m_irq[n] = 1'b0;
            end else begin
                mk = wmask(n);
                hist[n][cyc] = pin[n] & mk;
                if (d_of(n) == 0) begin
                    f_new = h(n, cyc - s_of(n) + 1);
                end else begin
                    f_new = m_f[n];
                    for (int b = 0; b < 32; b++) begin
                        flip = 1'b1;
                        for (int j = 0; j < d_of(n); j++) begin
                            sv = h(n, cyc - s_of(n) - j);
                            if (sv[b] == m_f[n][b]) flip = 1'b0;
                        end
                        if (flip) f_new[b] = ~m_f[n][b];
                    end
                end
                case (e_of(n))
                    0:       ed = m_f[n] & ~m_d[n];
                    1:       ed = ~m_f[n] & m_d[n];
                    default: ed = m_f[n] ^ m_d[n];
                endcase
                wr  = cs[n] & ~wn[n];
                clr = (wr && adr[n] == 2'd3) ? (wd[n] & mk) : 32'h0;
                case (adr[n])
                    2'd0:    m_rd[n] = m_f[n];
                    2'd2:    m_rd[n] = m_mask[n];
                    2'd3:    m_rd[n] = m_ec[n];
                    default: m_rd[n] = 32'h0;
                endcase
                m_irq[n] = |(m_ec[n] & m_mask[n]);
                m_d[n]   = m_f[n];
                m_ec[n]  = (m_ec[n] & ~clr) | ed;
                if (wr && adr[n] == 2'd2) m_mask[n] = wd[n] & mk;
                m_f[n]   = f_new;
            end
        end
        if (cyc < HN - 1) cyc++;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int n = 0; n < ND; n++) begin
                check($sformatf("model_rd%0d", n), dut_rd(n), m_rd[n]);
                check($sformatf("model_irq%0d", n), {31'h0, dut_irq(n)}, {31'h0, m_irq[n]});
            end
        end
    end

    task automatic wr(input int n, input logic [1:0] a, input logic [31:0] d);
        adr[n] = a; wd[n] = d; cs[n] = 1'b1; wn[n] = 1'b0;
        @(negedge clk);
        cs[n] = 1'b0; wn[n] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int n = 0; n < ND; n++) begin
            adr[n] = 2'd0; cs[n] = 1'b0; wn[n] = 1'b1; wd[n] = '0; pin[n] = '0;
        end
        pin[0] = 32'hFF;
        repeat (4) @(negedge clk);
        check("rst_rd_a", rd_a, 32'h0);
        check("rst_rd_b", rd_b, 32'h0);
        check("rst_rd_c", rd_c, 32'h0);
        check("rst_irq_a", {31'h0, irq_a}, 32'h0);

        // Reset release with all inputs high on A
        reset_n = 1'b1;
        @(negedge clk);
        check("a_first_read", rd_a, 32'h0);
        repeat (2) @(negedge clk);
        check("a_data_ff", rd_a, 32'hFF);
        check("model_pin_a_data", m_rd[0], 32'hFF);
        adr[0] = 2'd3;
        @(negedge clk);
        check("a_edgecap_ff", rd_a, 32'hFF);
        check("a_irq_masked", {31'h0, irq_a}, 32'h0);

        // Rising-edge irq latency and W1C
        wr(0, 2'd3, 32'hFF);
        wr(0, 2'd2, 32'h01);
        pin[0] = 32'h00;
        repeat (6) @(negedge clk);
        pin[0] = 32'h01;
        repeat (3) @(negedge clk);
        check("a_irq_early", {31'h0, irq_a}, 32'h0);
        @(negedge clk);
        check("a_irq_rise", {31'h0, irq_a}, 32'h1);
        adr[0] = 2'd3;
        @(negedge clk);
        check("a_edgecap_bit0", rd_a, 32'h1);
        wr(0, 2'd3, 32'h1);
        @(negedge clk);
        check("a_irq_cleared", {31'h0, irq_a}, 32'h0);
        check("a_edgecap_cleared", rd_a, 32'h0);

        // Write to DATA ignored, reserved reads 0, mask width limited
        wr(0, 2'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("a_data_wr_ignored", rd_a, 32'h1);
        wr(0, 2'd1, 32'hFFFF_FFFF);
        @(negedge clk);
        check("a_reserved", rd_a, 32'h0);
        wr(0, 2'd2, 32'hFFFF_FFFF);
        @(negedge clk);
        check("a_mask_readback", rd_a, 32'hFF);

        // Same-cycle W1C and new edge on bit 2: set wins
        pin[0] = 32'h05;
        repeat (2) @(negedge clk);
        wr(0, 2'd3, 32'h4);
        @(negedge clk);
        check("a_set_wins", rd_a, 32'h4);
        check("a_set_wins_irq", {31'h0, irq_a}, 32'h1);
        wr(0, 2'd3, 32'hFF);

        // Debounce on B: 3-cycle pulses are rejected
        adr[1] = 2'd0;
        for (int p = 0; p < 4; p++) begin
            pin[1] = 32'h2;
            repeat (3) @(negedge clk);
            pin[1] = 32'h0;
            repeat (3) @(negedge clk);
            check("b_bounce_data", rd_b, 32'h0);
        end
        adr[1] = 2'd3;
        @(negedge clk);
        check("b_bounce_edgecap", rd_b, 32'h0);
        adr[1] = 2'd0;
        pin[1] = 32'h2;
        repeat (6) @(negedge clk);
        check("b_db_not_yet", rd_b, 32'h0);
        @(negedge clk);
        check("b_db_settled", rd_b, 32'h2);

        // Falling-only capture on B
        pin[1] = 32'h0A;
        repeat (12) @(negedge clk);
        adr[1] = 2'd3;
        @(negedge clk);
        check("b_rise_no_cap", rd_b, 32'h0);
        pin[1] = 32'h02;
        repeat (12) @(negedge clk);
        check("b_fall_cap", rd_b, 32'h8);

        // Any-edge capture and full-width mask on C
        adr[2] = 2'd3;
        pin[2] = 32'h8000_0000;
        repeat (10) @(negedge clk);
        check("c_rise_cap", rd_c, 32'h8000_0000);
        wr(2, 2'd3, 32'hFFFF_FFFF);
        pin[2] = 32'h0;
        repeat (10) @(negedge clk);
        check("c_fall_cap", rd_c, 32'h8000_0000);
        wr(2, 2'd2, 32'hFFFF_FFFF);
        @(negedge clk);
        check("c_mask_readback", rd_c, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        check("c_irq", {31'h0, irq_c}, 32'h1);

        // Randomised traffic with one mid-run reset
        for (int i = 0; i < 2000; i++) begin
            for (int n = 0; n < ND; n++) begin
                if (n == 1) begin
                    if ($urandom_range(0, 5) == 0) pin[n] = pin[n] ^ (32'h1 << $urandom_range(0, 7));
                end else if ($urandom_range(0, 2) == 0) begin
                    pin[n] = $urandom;
                end
                adr[n] = 2'($urandom_range(0, 3));
                cs[n]  = 1'($urandom_range(0, 1));
                wn[n]  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                wd[n]  = $urandom;
            end
            if (i == 1000) begin
                reset_n = 1'b0;
                repeat (3) @(negedge clk);
                check("mid_rst_rd_b", rd_b, 32'h0);
                check("mid_rst_irq_c", {31'h0, irq_c}, 32'h0);
                reset_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
